nsu_vc_drain_scheduler: RTL and testbench

NSU_VC_DRAIN_SCHEDULER -- requirements
Module: nsu_vc_drain_scheduler

---
 rtl/nsu_vc_drain_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_nsu_vc_drain_scheduler.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/nsu_vc_drain_scheduler.sv
// Drains a set of NSU virtual-channel FIFOs in ascending VC order, len+1 beats each,
// with one pending-set slot, empty-FIFO timeout abort and sticky error flags.
module nsu_vc_drain_scheduler #(
  parameter int VIRTUAL_CH_NUM = 16,
  parameter int TIMEOUT_CYC    = 1023
) (
  input  logic                      noc_clk,
  input  logic                      noc_rst_n,
  input  logic                      nocpack_done,
  input  logic [VIRTUAL_CH_NUM-1:0] pack_num,
  input  logic [7:0]                axi_len,
  input  logic [VIRTUAL_CH_NUM-1:0] empty_vc,
  input  logic                      dn_ready,
  output logic [VIRTUAL_CH_NUM-1:0] rd_en,
  output logic                      beat_valid,
  output logic                      sub_last,
  output logic                      set_last,
  output logic                      busy,
  output logic                      set_done,
  output logic                      err_timeout,
  output logic                      err_overflow
);

  localparam int CW = (VIRTUAL_CH_NUM > 1) ? $clog2(VIRTUAL_CH_NUM) : 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEL   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t                    state_r;
  logic [VIRTUAL_CH_NUM-1:0] mask_r;
  logic [7:0]                len_r;
  logic [CW-1:0]             cur_r;
  logic [8:0]                beat_cnt_r;
  logic [TW-1:0]             to_cnt_r;
  logic                      pend_valid_r;
  logic [VIRTUAL_CH_NUM-1:0] pend_mask_r;
  logic [7:0]                pend_len_r;
  logic                      beat_valid_r;
  logic                      sub_last_r;
  logic                      set_last_r;
  logic                      set_done_r;
  logic                      err_timeout_r;
  logic                      err_overflow_r;

  logic [VIRTUAL_CH_NUM-1:0] cur_bit_s;
  logic [VIRTUAL_CH_NUM-1:0] rest_s;
  logic [VIRTUAL_CH_NUM-1:0] rd_en_s;
  logic                      issue_s;
  logic                      last_beat_s;

  function automatic logic [CW-1:0] lowest_idx(input logic [VIRTUAL_CH_NUM-1:0] m);
    lowest_idx = {CW{1'b0}};
    for (int i = VIRTUAL_CH_NUM - 1; i >= 0; i--) begin
      if (m[i]) lowest_idx = i[CW-1:0];
    end
  endfunction

  // read strobe decode and last-beat/last-VC detection for the current VC
  always_comb begin
    cur_bit_s = {VIRTUAL_CH_NUM{1'b0}};
    for (int i = 0; i < VIRTUAL_CH_NUM; i++) begin
      cur_bit_s[i] = (cur_r == i[CW-1:0]);
    end
    rest_s      = mask_r & ~cur_bit_s;
    last_beat_s = (beat_cnt_r == {1'b0, len_r});
    if ((state_r == ST_DRAIN) && !empty_vc[cur_r] && dn_ready && (beat_cnt_r <= {1'b0, len_r})) begin
      rd_en_s = cur_bit_s;
    end else begin
      rd_en_s = {VIRTUAL_CH_NUM{1'b0}};
    end
    issue_s = |rd_en_s;
  end

  // scheduler FSM, pending slot, beat flags and sticky errors
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      state_r        <= ST_IDLE;
      mask_r         <= {VIRTUAL_CH_NUM{1'b0}};
      len_r          <= 8'd0;
      cur_r          <= {CW{1'b0}};
      beat_cnt_r     <= 9'd0;
      to_cnt_r       <= {TW{1'b0}};
      pend_valid_r   <= 1'b0;
      pend_mask_r    <= {VIRTUAL_CH_NUM{1'b0}};
      pend_len_r     <= 8'd0;
      beat_valid_r   <= 1'b0;
      sub_last_r     <= 1'b0;
      set_last_r     <= 1'b0;
      set_done_r     <= 1'b0;
      err_timeout_r  <= 1'b0;
      err_overflow_r <= 1'b0;
    end else begin
      set_done_r   <= 1'b0;
      beat_valid_r <= issue_s;
      sub_last_r   <= issue_s & last_beat_s;
      set_last_r   <= issue_s & last_beat_s & ~(|rest_s);
      case (state_r)
        ST_IDLE: begin
          if (nocpack_done) begin
            mask_r  <= pack_num;
            len_r   <= axi_len;
            state_r <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (|mask_r) begin
            cur_r   <= lowest_idx(mask_r);
            state_r <= ST_DRAIN;
          end else begin
            state_r    <= ST_DONE;
            set_done_r <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (issue_s) begin
            to_cnt_r <= {TW{1'b0}};
            if (last_beat_s) begin
              beat_cnt_r <= 9'd0;
              state_r    <= ST_NEXT;
            end else begin
              beat_cnt_r <= beat_cnt_r + 9'd1;
            end
          end else if (empty_vc[cur_r]) begin
            if (to_cnt_r == TW'(TIMEOUT_CYC - 1)) begin
              err_timeout_r <= 1'b1;
              mask_r        <= {VIRTUAL_CH_NUM{1'b0}};
              beat_cnt_r    <= 9'd0;
              to_cnt_r      <= {TW{1'b0}};
              state_r       <= ST_DONE;
              set_done_r    <= 1'b1;
            end else begin
              to_cnt_r <= to_cnt_r + TW'(1);
            end
          end
        end
        ST_NEXT: begin
          mask_r <= rest_s;
          if (|rest_s) begin
            state_r <= ST_SEL;
          end else begin
            state_r    <= ST_DONE;
            set_done_r <= 1'b1;
          end
        end
        ST_DONE: begin
          // a set arriving in this very cycle with the slot empty is started directly
          if (pend_valid_r) begin
            mask_r       <= pend_mask_r;
            len_r        <= pend_len_r;
            pend_valid_r <= 1'b0;
            state_r      <= ST_SEL;
          end else if (nocpack_done) begin
            mask_r  <= pack_num;
            len_r   <= axi_len;
            state_r <= ST_SEL;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
      if (nocpack_done && (state_r != ST_IDLE)) begin
        if (state_r == ST_DONE) begin
          if (pend_valid_r) begin
            pend_valid_r <= 1'b1;
            pend_mask_r  <= pack_num;
            pend_len_r   <= axi_len;
          end
        end else if (!pend_valid_r) begin
          pend_valid_r <= 1'b1;
          pend_mask_r  <= pack_num;
          pend_len_r   <= axi_len;
        end else begin
          err_overflow_r <= 1'b1;
        end
      end
    end
  end

  assign rd_en        = rd_en_s;
  assign beat_valid   = beat_valid_r;
  assign sub_last     = sub_last_r;
  assign set_last     = set_last_r;
  assign busy         = (state_r != ST_IDLE);
  assign set_done     = set_done_r;
  assign err_timeout  = err_timeout_r;
  assign err_overflow = err_overflow_r;

endmodule

// File: tb/tb_nsu_vc_drain_scheduler.sv
// Directed bench with a beat scoreboard: expected {vc, sub_last, set_last} per read are
// queued when a set is issued and checked against rd_en and the following beat flags.
module tb_nsu_vc_drain_scheduler;

  logic        noc_clk = 1'b0;
  logic        noc_rst_n = 1'b0;
  logic        nocpack_done = 1'b0;
  logic [15:0] pack_num = 16'h0;
  logic [7:0]  axi_len = 8'd0;
  logic [15:0] empty_vc = 16'h0;
  logic        dn_ready = 1'b1;
  logic [15:0] rd_en;
  logic        beat_valid, sub_last, set_last, busy, set_done, err_timeout, err_overflow;

  int checks = 0;
  int failures = 0;
  int beats = 0;
  int sd_cnt = 0;
  logic [5:0] exp_q[$];
  logic [5:0] item;
  logic [5:0] prev_item;
  logic       have_prev = 1'b0;

  nsu_vc_drain_scheduler #(.VIRTUAL_CH_NUM(16), .TIMEOUT_CYC(8)) dut (
    .noc_clk(noc_clk), .noc_rst_n(noc_rst_n), .nocpack_done(nocpack_done),
    .pack_num(pack_num), .axi_len(axi_len), .empty_vc(empty_vc), .dn_ready(dn_ready),
    .rd_en(rd_en), .beat_valid(beat_valid), .sub_last(sub_last), .set_last(set_last),
    .busy(busy), .set_done(set_done), .err_timeout(err_timeout), .err_overflow(err_overflow)
  );

  always #5 noc_clk = ~noc_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // scoreboard monitor: reads are popped and checked, beats checked one cycle later
  always @(negedge noc_clk) begin
    if (beat_valid || have_prev) begin
      chk("beat_follows_read", 32'(beat_valid), 32'(have_prev));
      if (beat_valid && have_prev) begin
        chk("sub_last", 32'(sub_last), 32'(prev_item[1]));
        chk("set_last", 32'(set_last), 32'(prev_item[0]));
      end
      if (beat_valid) beats++;
    end
    have_prev = 1'b0;
    if (rd_en != 16'h0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_read", 32'(rd_en), 32'h0);
      end else begin
        item = exp_q.pop_front();
        chk("rd_en_vc", 32'(rd_en), 32'(16'd1 << item[5:2]));
        prev_item = item;
        have_prev = 1'b1;
      end
    end
    if (set_done) sd_cnt++;
  end

  task automatic push_set(input logic [15:0] m, input int len);
    int hi;
    hi = -1;
    for (int v = 0; v < 16; v++) if (m[v]) hi = v;
    for (int v = 0; v < 16; v++) begin
      if (m[v]) begin
        for (int b = 0; b <= len; b++) begin
          exp_q.push_back({v[3:0], (b == len), (b == len) && (v == hi)});
        end
      end
    end
  endtask

  task automatic pulse(input logic [15:0] m, input logic [7:0] len);
    @(posedge noc_clk); #1;
    nocpack_done = 1'b1;
    pack_num = m;
    axi_len = len;
    @(posedge noc_clk); #1;
    nocpack_done = 1'b0;
  endtask

  task automatic wait_idle(input bit toggle, output int cyc);
    cyc = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge noc_clk);
      if (!busy) break;
      cyc++;
      @(posedge noc_clk); #1;
      if (toggle) dn_ready = ~dn_ready;
    end
    chk("idle_reached", 32'(busy), 32'h0);
    @(posedge noc_clk); #1;
    dn_ready = 1'b1;
  endtask

  initial begin
    int cyc, b0, s0;
    #3;
    chk("rst_rd_en", 32'(rd_en), 32'h0);
    chk("rst_beat_valid", 32'(beat_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_set_done", 32'(set_done), 32'h0);
    chk("rst_errs", 32'({err_timeout, err_overflow}), 32'h0);
    @(negedge noc_clk);
    noc_rst_n = 1'b1;

    // two VCs, four beats each
    b0 = beats; s0 = sd_cnt;
    push_set(16'h0005, 3);
    pulse(16'h0005, 8'd3);
    wait_idle(1'b0, cyc);
    chk("t1_busy_cycles", 32'(cyc), 32'd13);
    chk("t1_beats", 32'(beats - b0), 32'd8);
    chk("t1_set_done", 32'(sd_cnt - s0), 32'd1);
    chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

    // empty mask
    b0 = beats; s0 = sd_cnt;
    pulse(16'h0000, 8'd5);
    wait_idle(1'b0, cyc);
    chk("t2_busy_cycles", 32'(cyc), 32'd2);
    chk("t2_beats", 32'(beats - b0), 32'd0);
    chk("t2_set_done", 32'(sd_cnt - s0), 32'd1);

    // dn_ready toggling
    b0 = beats; s0 = sd_cnt;
    push_set(16'h0003, 1);
    pulse(16'h0003, 8'd1);
    wait_idle(1'b1, cyc);
    chk("t3_beats", 32'(beats - b0), 32'd4);
    chk("t3_set_done", 32'(sd_cnt - s0), 32'd1);
    chk("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // empty VC timeout
    b0 = beats; s0 = sd_cnt;
    empty_vc = 16'h0002;
    pulse(16'h0002, 8'd0);
    wait_idle(1'b0, cyc);
    empty_vc = 16'h0000;
    chk("t4_busy_cycles", 32'(cyc), 32'd10);
    chk("t4_err_timeout", 32'(err_timeout), 32'd1);
    chk("t4_set_done", 32'(sd_cnt - s0), 32'd1);
    chk("t4_beats", 32'(beats - b0), 32'd0);
    chk("t4_no_overflow", 32'(err_overflow), 32'd0);

    // new set arriving during DONE is kept
    b0 = beats; s0 = sd_cnt;
    push_set(16'h0001, 0);
    push_set(16'h0002, 0);
    pulse(16'h0001, 8'd0);
    @(posedge noc_clk);
    @(posedge noc_clk); #1;
    pulse(16'h0002, 8'd0);
    wait_idle(1'b0, cyc);
    chk("t5_busy_cycles", 32'(cyc), 32'd4);
    chk("t5_beats", 32'(beats - b0), 32'd2);
    chk("t5_set_done", 32'(sd_cnt - s0), 32'd2);
    chk("t5_no_overflow", 32'(err_overflow), 32'd0);

    // pending slot and overflow
    b0 = beats; s0 = sd_cnt;
    push_set(16'h0001, 1);
    push_set(16'h0004, 0);
    pulse(16'h0001, 8'd1);
    pulse(16'h0004, 8'd0);
    chk("t6_no_overflow_yet", 32'(err_overflow), 32'd0);
    pulse(16'h0008, 8'd0);
    chk("t6_overflow", 32'(err_overflow), 32'd1);
    wait_idle(1'b0, cyc);
    chk("t6_beats", 32'(beats - b0), 32'd3);
    chk("t6_set_done", 32'(sd_cnt - s0), 32'd2);
    chk("t6_q_empty", 32'(exp_q.size()), 32'd0);
    chk("t6_timeout_sticky", 32'(err_timeout), 32'd1);

    // reset in the middle of a drain
    push_set(16'h0001, 7);
    pulse(16'h0001, 8'd7);
    @(posedge noc_clk);
    @(posedge noc_clk);
    @(posedge noc_clk); #1;
    chk("t7_draining", 32'(rd_en), 32'h0001);
    noc_rst_n = 1'b0;
    #1;
    chk("t7_rd_en_off", 32'(rd_en), 32'h0);
    chk("t7_beat_off", 32'(beat_valid), 32'h0);
    chk("t7_busy_off", 32'(busy), 32'h0);
    chk("t7_errs_cleared", 32'({err_timeout, err_overflow}), 32'h0);
    exp_q.delete();
    have_prev = 1'b0;
    @(negedge noc_clk);
    noc_rst_n = 1'b1;
    b0 = beats; s0 = sd_cnt;
    push_set(16'h0006, 1);
    pulse(16'h0006, 8'd1);
    wait_idle(1'b0, cyc);
    chk("t7_busy_cycles", 32'(cyc), 32'd9);
    chk("t7_beats", 32'(beats - b0), 32'd4);
    chk("t7_set_done", 32'(sd_cnt - s0), 32'd1);
    chk("t7_q_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
